// File: rtl/traceback_engine.sv
// traceback_engine: walks the two-piece affine DP backwards from an end cell and streams alignment ops
module traceback_engine #(
  parameter int N               = 16,
  parameter int DIRECTION_WIDTH = 7,
  parameter int ADDRESS_WIDTH   = 10,
  parameter int IDX_WIDTH       = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [IDX_WIDTH-1:0]         start_i,
  input  logic [IDX_WIDTH-1:0]         start_j,
  output logic                         ren,
  output logic [ADDRESS_WIDTH-1:0]     read_address,
  input  logic [DIRECTION_WIDTH*N-1:0] q,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [1:0]                   op,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_DECODE = 3'd2, S_EMIT = 3'd3, S_FLUSH = 3'd4;
  localparam logic [2:0] C_H = 3'd0, SRC_DIAG = 3'd0, SRC_STOP = 3'd5;
  localparam logic [1:0] OP_M = 2'd0, OP_I = 2'd1, OP_D = 2'd2;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [IDX_WIDTH:0] ONE = 1;
  logic [2:0] r_state, r_cur;
  logic signed [IDX_WIDTH:0] r_i, r_j;
  logic [DIRECTION_WIDTH-1:0] r_d;
  logic [1:0] r_op;
  logic r_done, r_err;
  logic [SW-1:0] w_slot;
  logic [DIRECTION_WIDTH-1:0] w_q_d;
  logic w_ext, w_ineg, w_jneg;
  assign w_slot       = r_i[SW-1:0];
  assign w_q_d        = q[w_slot*DIRECTION_WIDTH +: DIRECTION_WIDTH];
  assign w_ext        = r_d[r_cur + 3'd2];
  assign w_ineg       = r_i[IDX_WIDTH];
  assign w_jneg       = r_j[IDX_WIDTH];
  assign ren          = r_state == S_ISSUE;
  assign read_address = ADDRESS_WIDTH'(r_i + r_j);
  assign op_valid     = r_state == S_EMIT || r_state == S_FLUSH;
  assign op           = r_op;
  assign busy         = r_state != S_IDLE;
  assign done         = r_done;
  assign err          = r_err;
  // walk FSM: one read per cell, direction word captured as it arrives so q need not be held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cur   <= C_H;
      r_i     <= '0;
      r_j     <= '0;
      r_d     <= '0;
      r_op    <= OP_M;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_i     <= signed'({1'b0, start_i});
          r_j     <= signed'({1'b0, start_j});
          r_cur   <= C_H;
          r_err   <= 1'b0;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_d     <= w_q_d;
          r_state <= S_DECODE;
        end
        S_DECODE: if (r_cur == C_H) begin
          if (r_d[2:0] == SRC_DIAG) begin
            r_op    <= OP_M;
            r_i     <= r_i - ONE;
            r_j     <= r_j - ONE;
            r_state <= S_EMIT;
          end else if (r_d[2:0] < SRC_STOP) begin
            r_cur <= r_d[2:0];
          end else begin
            r_err   <= r_d[2:0] != SRC_STOP;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end else begin
          r_op    <= r_cur[0] ? OP_D : OP_I;
          r_i     <= r_cur[0] ? r_i : r_i - ONE;
          r_j     <= r_cur[0] ? r_j - ONE : r_j;
          r_cur   <= w_ext ? r_cur : C_H;
          r_state <= S_EMIT;
        end
        S_EMIT: if (op_ready) begin
          if (w_ineg && w_jneg) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_ineg || w_jneg) begin
            r_op    <= w_ineg ? OP_D : OP_I;
            r_state <= S_FLUSH;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_FLUSH: if (op_ready) begin
          r_i <= w_ineg ? r_i : r_i - ONE;
          r_j <= w_ineg ? r_j - ONE : r_j;
          if ((w_ineg ? r_j : r_i) == '0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_traceback_engine.sv
// tb_traceback_engine: directed walks with a scoreboard checking reads, ops and done/err
module tb_traceback_engine;
  localparam int N = 4, DW = 7, AW = 10, IW = 10;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_ready = 1'b1;
  logic [IW-1:0] start_i = '0, start_j = '0;
  logic ren, op_valid, busy, done, err;
  logic [AW-1:0] read_address;
  logic [N*DW-1:0] q = '0;
  logic [1:0] op;
  logic [N*DW-1:0] mem [0:15];
  int n_chk = 0, n_fail = 0;
  int exp_ops[$];
  int exp_addr[$];
  traceback_engine #(.N(N), .DIRECTION_WIDTH(DW), .ADDRESS_WIDTH(AW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_i(start_i), .start_j(start_j),
    .ren(ren), .read_address(read_address), .q(q), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (ren) q <= mem[read_address[3:0]];
  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  // scoreboard monitor: every read, handshake and done pulse must match the next expectation
  always @(negedge clk) if (rst_n) begin
    if (ren) begin
      if (exp_addr.size() == 0) chk("extra_ren", int'(read_address), -1);
      else chk("addr", int'(read_address), exp_addr.pop_front());
    end
    if (op_valid && op_ready) begin
      if (exp_ops.size() == 0) chk("extra_op", int'(op), -1);
      else chk("op", int'(op), exp_ops.pop_front());
    end
    if (done) begin
      if (exp_ops.size() == 0) chk("extra_done", 8 + int'(err), -1);
      else chk("done_err", 8 + int'(err), exp_ops.pop_front());
      chk("busy_at_done", int'(busy), 0);
    end
  end
  task automatic fill(input logic [DW-1:0] d);
    for (int a = 0; a < 16; a++) for (int k = 0; k < N; k++) mem[a][k*DW +: DW] = d;
  endtask
  task automatic set_cell(input int i, input int j, input logic [DW-1:0] d);
    mem[i+j][i*DW +: DW] = d;
  endtask
  task automatic go(input int i, input int j);
    @(negedge clk);
    start_i = i[IW-1:0];
    start_j = j[IW-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string name, input int exp_n);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({name, "_done"}, int'(done), 1);
    if (done && exp_n >= 0) chk({name, "_cycles"}, n, exp_n);
    chk({name, "_left"}, exp_ops.size() + exp_addr.size(), 0);
    @(negedge clk);
    chk({name, "_pulse"}, int'(done), 0);
  endtask
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!op_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, int'(op_valid), 1);
  endtask
  initial begin
    fill('0);
    #12;
    chk("rst_ren", int'(ren), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(op_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_addr", int'(read_address), 0);
    chk("idle_op", int'(op), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_err", int'(err), 0);
    exp_addr = '{6, 4, 2, 0};
    exp_ops  = '{0, 0, 0, 0, 8};
    go(3, 3);
    wait_done("diag", 12);
    set_cell(2, 5, 7'h09);
    set_cell(2, 4, 7'h08);
    set_cell(2, 3, 7'h00);
    exp_addr = '{7, 6, 5, 4, 2, 0};
    exp_ops  = '{2, 2, 2, 0, 0, 0, 8};
    go(2, 5);
    wait_done("gap", 19);
    fill('0);
    exp_addr = '{1};
    exp_ops  = '{0, 1, 8};
    go(1, 0);
    wait_done("flush", 4);
    set_cell(2, 2, 7'd5);
    exp_addr = '{6, 4};
    exp_ops  = '{0, 8};
    go(3, 3);
    wait_done("stop", 5);
    fill('0);
    set_cell(3, 3, 7'd6);
    exp_addr = '{6};
    exp_ops  = '{9};
    go(3, 3);
    wait_done("illegal", 2);
    chk("err_sticky", int'(err), 1);
    fill('0);
    exp_addr = '{6, 4, 2, 0};
    exp_ops  = '{0, 0, 0, 0, 8};
    op_ready = 1'b0;
    go(3, 3);
    wait_valid("stall");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start   = (c == 1);
      start_i = '0;
      start_j = '0;
      chk("stall_hold_valid", int'(op_valid), 1);
      chk("stall_hold_op", int'(op), 0);
      chk("stall_no_ren", int'(ren), 0);
    end
    start = 1'b0;
    op_ready = 1'b1;
    wait_done("stall", -1);
    exp_addr = '{6};
    exp_ops.delete();
    op_ready = 1'b0;
    go(3, 3);
    wait_valid("rst_mid");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(op_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ren", int'(ren), 0);
    chk("rst_mid_done", int'(done), 0);
    exp_addr.delete();
    exp_ops.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    op_ready = 1'b1;
    exp_addr = '{6, 4, 2, 0};
    exp_ops  = '{0, 0, 0, 0, 8};
    go(3, 3);
    wait_done("after_rst", 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/traceback_engine.md
Name: traceback_engine

Overview:
- Consumer stage directly downstream of the traceback direction memory.
- After the PE array has finished writing direction words, it walks the two-piece affine DP backwards from a given end cell.
- It reads one direction word per visited cell and emits one alignment op per step through a valid/ready stream, for the CIGAR/output stage.
- Memory layout: the word at address `t` holds slot `k` = direction of cell (i=k, j=t-k). `k` is the PE/query index and `j` is the reference index, so cell (i,j) sits at address i+j, slot i.

Parameters:
- N, 16, PE count / query length; direction slots per memory word.
- DIRECTION_WIDTH, 7, bits per cell.
  - [2:0] H source: 0=DIAG, 1=E1, 2=F1, 3=E2, 4=F2, 5=STOP, 6/7 illegal.
  - [3] E1 extend, [4] F1 extend, [5] E2 extend, [6] F2 extend.
- ADDRESS_WIDTH, 10, memory address width.
- IDX_WIDTH, 10, width of i/j indices.

Ports:
- clk  in  1  clock; engine logic on posedge (memory samples on negedge).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- start_i  in  IDX_WIDTH  end-cell query index, must be < N.
- start_j  in  IDX_WIDTH  end-cell reference index.
- ren  out  1  memory read enable.
- read_address  out  ADDRESS_WIDTH  = i+j, truncated to ADDRESS_WIDTH.
- q  in  DIRECTION_WIDTH*N  memory read data; slot k = q[k*DIRECTION_WIDTH +: DIRECTION_WIDTH].
- op_valid  out  1  op available.
- op_ready  in  1  consumer accepts op.
- op  out  2  0=MATCH(i--,j--), 1=INS(i--), 2=DEL(j--), 3 unused.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when traceback ends.
- err  out  1  sticky until next start; illegal H source was seen.

Behaviour:
- Reset (asynchronous, mid-walk included): state=IDLE; ren, op_valid, op, busy, done, err=0; read_address=0; cur=H. Reset abandons the walk; no done pulse.
- Internal regs: i, j (signed IDX_WIDTH+1), cur ∈ {H,E1,F1,E2,F2}, state ∈ {IDLE,ISSUE,DECODE,EMIT,FLUSH}.
- IDLE: on start, latch i=start_i, j=start_j, cur=H, clear err, go to ISSUE. A start while not IDLE is ignored.
- ISSUE: ren=1, read_address=i+j for exactly one cycle, then go to DECODE. Memory latches q on the intervening negedge, so q is valid at the next posedge. Read latency is one cycle.
- DECODE: select slot d = q[i*DIRECTION_WIDTH +: DIRECTION_WIDTH]. Register d so q need not be held.
  - cur=H, src DIAG: op=MATCH, i--, j--, go to EMIT.
  - cur=H, src E1/F1/E2/F2: set cur to that matrix and stay in DECODE using the registered d. No new read and no op.
  - cur=H, src STOP: done, go to IDLE. Local end; no op emitted.
  - cur=H, src illegal: err=1, done, go to IDLE.
  - cur=E1/E2: op=DEL, j--. The next cur stays the same if that matrix's extend bit is set, else returns to H. Go to EMIT.
  - cur=F1/F2: op=INS, i--. Extend-bit rule as for E; go to EMIT.
- EMIT: hold op_valid=1 and op stable until op_ready. On handshake:
  - i<0 and j<0: done, go to IDLE.
  - exactly one of i, j <0: go to FLUSH.
  - otherwise go to ISSUE.
- FLUSH: no memory reads. Emit INS while i>=0 (i--), or DEL while j>=0 (j--), one op per handshake. When both are <0: done, go to IDLE.
- Throughput: with op_ready held high, 3 cycles per cell (ISSUE, DECODE, EMIT); 1 op per cycle in FLUSH. An H-to-gap-matrix redirect adds 1 DECODE cycle.
- op_valid never drops without a handshake, except on reset.
- done pulses in the cycle the engine returns to IDLE; busy is low in that cycle.
- read_address is only meaningful while ren=1.

Test Plan:
- N=4, all cells DIAG, start_i=3, start_j=3 -> reads addr 6,4,2,0, slots 3,2,1,0; ops MATCH×4; done after 4th handshake; 12 cycles with op_ready=1.
- (2,5): H src=E1 at (2,5), E1 ext set at (2,5),(2,4), clear at (2,3), DIAG elsewhere -> DEL,DEL,DEL, then MATCH,MATCH,MATCH at (2,2),(1,1),(0,0); cur returns to H after the 3rd DEL.
- (1,0): DIAG -> MATCH, then j=-1, i=0 -> FLUSH emits INS ×1 with no ren; done.
- STOP at (2,2) with start (3,3) DIAG -> MATCH, then done with no further op; err=0. Illegal src 6 at start cell -> err=1, done, no op.
- op_ready low for 5 cycles in EMIT -> op_valid and op held stable, no ren asserted; start pulsed mid-walk is ignored.
- rst_n low during EMIT -> op_valid, busy, ren=0 asynchronously; a new start after release runs a clean walk.
